// File: rtl/xy2_100_pkg.sv
// Shared XY2-100 framing constants and the parity helper used by both the
// transmitter and the scanner feedback receiver.
package xy2_100_pkg;

    localparam int unsigned FRAME_BITS         = 20;
    localparam logic [2:0]  CTRL_BITS          = 3'b001;
    localparam int unsigned DEFAULT_BIT_PERIOD = 20;

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_SEND = 1'b1;

    // Odd parity over the 16 data bits: the frame's parity bit.
    function automatic logic xy2_parity(input logic [15:0] d);
        return 1'b1 ^ (^d);
    endfunction

endpackage

// File: rtl/xy2_100_frame_ser.sv
// One XY2-100 channel: a 20-bit frame shift register, b0 at the MSB.
// Shifting in zeros means one extra shift after the parity bit drives the line low.
module xy2_100_frame_ser
    import xy2_100_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic [15:0] data_i,
    output logic        bit_o
);

    logic [FRAME_BITS-1:0] sr_q;
    logic [FRAME_BITS-1:0] sr_d;

    // Next frame contents: fresh load, shift toward the MSB, or hold.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = {CTRL_BITS, data_i, xy2_parity(data_i)};
        end else if (shift_i) begin
            sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_o = sr_q[FRAME_BITS-1];

endmodule

// File: rtl/xy2_100_tx.sv
// XY2-100 command transmitter: valid/ready X/Y commands with a one-deep holding
// register, serialized as back-to-back frames on CLOCK/SYNC/X/Y.
module xy2_100_tx
    import xy2_100_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = DEFAULT_BIT_PERIOD,
    parameter int unsigned REPEAT     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    output logic        xy2_clk,
    output logic        xy2_sync,
    output logic        xy2_x,
    output logic        xy2_y,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned PW       = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(BIT_PERIOD - 1);
    localparam logic [PW-1:0] PER_HALF = PW'(BIT_PERIOD / 2);
    localparam logic [4:0]    BIT_LAST = 5'(FRAME_BITS - 1);

    logic [0:0]    state_q,  state_d;
    logic [PW-1:0] period_q, period_d;
    logic [4:0]    bit_q,    bit_d;
    logic          hold_full_q, hold_full_d;
    logic [15:0]   hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    logic [15:0]   last_x_q, last_x_d, last_y_q, last_y_d;
    logic          cmd_ready_q, clk_q, sync_q, busy_q, done_q;

    logic          accept_s, bit_end_s, frame_end_s, load_s, shift_s;
    logic [15:0]   load_x_s, load_y_s;

    assign accept_s    = cmd_valid && cmd_ready_q;
    assign bit_end_s   = (state_q == ST_SEND) && (period_q == PER_LAST);
    assign frame_end_s = bit_end_s && (bit_q == BIT_LAST);

    // Frame sequencing, holding register and the frame-end priority chain.
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        bit_d       = bit_q;
        hold_full_d = hold_full_q;
        hold_x_d    = hold_x_q;
        hold_y_d    = hold_y_q;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        load_x_s    = cmd_x;
        load_y_s    = cmd_y;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_SEND;
                    period_d = '0;
                    bit_d    = 5'd0;
                    load_s   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!frame_end_s) begin
                    if (bit_end_s) begin
                        period_d = '0;
                        bit_d    = bit_q + 5'd1;
                        shift_s  = 1'b1;
                    end else begin
                        period_d = period_q + PW'(1);
                    end
                    if (accept_s) begin
                        hold_full_d = 1'b1;
                        hold_x_d    = cmd_x;
                        hold_y_d    = cmd_y;
                    end else begin
                        hold_full_d = hold_full_q;
                    end
                end else begin
                    period_d = '0;
                    bit_d    = 5'd0;
                    // A full holding register keeps cmd_ready low, so accept_s
                    // can only be the bypass case here.
                    if (hold_full_q) begin
                        load_s      = 1'b1;
                        load_x_s    = hold_x_q;
                        load_y_s    = hold_y_q;
                        hold_full_d = 1'b0;
                    end else if (accept_s) begin
                        load_s      = 1'b1;
                    end else if (REPEAT != 0) begin
                        load_s      = 1'b1;
                        load_x_s    = last_x_q;
                        load_y_s    = last_y_q;
                    end else begin
                        state_d     = ST_IDLE;
                        shift_s     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        last_x_d = load_s ? load_x_s : last_x_q;
        last_y_d = load_s ? load_y_s : last_y_q;
    end

    // Sequencer state plus registered line levels derived from next-state counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            bit_q       <= 5'd0;
            hold_full_q <= 1'b0;
            hold_x_q    <= 16'h0000;
            hold_y_q    <= 16'h0000;
            last_x_q    <= 16'h0000;
            last_y_q    <= 16'h0000;
            cmd_ready_q <= 1'b1;
            clk_q       <= 1'b0;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            bit_q       <= bit_d;
            hold_full_q <= hold_full_d;
            hold_x_q    <= hold_x_d;
            hold_y_q    <= hold_y_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            cmd_ready_q <= !hold_full_d;
            clk_q       <= (state_d == ST_SEND) && (period_d < PER_HALF);
            sync_q      <= (state_d == ST_SEND) && (bit_d != BIT_LAST);
            busy_q      <= (state_d == ST_SEND);
            done_q      <= (state_d == ST_SEND) && (period_d == PER_LAST) && (bit_d == BIT_LAST);
        end
    end

    xy2_100_frame_ser u_ser_x (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .load_i  (load_s),
        .shift_i (shift_s),
        .data_i  (load_x_s),
        .bit_o   (xy2_x)
    );

    xy2_100_frame_ser u_ser_y (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .load_i  (load_s),
        .shift_i (shift_s),
        .data_i  (load_y_s),
        .bit_o   (xy2_y)
    );

    assign cmd_ready  = cmd_ready_q;
    assign xy2_clk    = clk_q;
    assign xy2_sync   = sync_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_xy2_100_tx.sv
// Directed bench for xy2_100_tx: one instance with REPEAT=0, one with REPEAT=1.
module tb_xy2_100_tx;

    localparam int BP = 20;
    localparam int FL = 20 * BP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, v0, rdy0, c0, s0, dx0, dy0, b0, fd0;
    logic        rst1_n, v1, rdy1, c1, s1, dx1, dy1, b1, fd1;
    logic [15:0] x0, y0, x1, y1;

    xy2_100_tx #(.BIT_PERIOD(BP), .REPEAT(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .cmd_valid(v0), .cmd_ready(rdy0),
        .cmd_x(x0), .cmd_y(y0), .xy2_clk(c0), .xy2_sync(s0),
        .xy2_x(dx0), .xy2_y(dy0), .busy(b0), .frame_done(fd0)
    );

    xy2_100_tx #(.BIT_PERIOD(BP), .REPEAT(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .cmd_valid(v1), .cmd_ready(rdy1),
        .cmd_x(x1), .cmd_y(y1), .xy2_clk(c1), .xy2_sync(s1),
        .xy2_x(dx1), .xy2_y(dy1), .busy(b1), .frame_done(fd1)
    );

    // Observation mux: sel picks which instance the helper tasks look at.
    logic sel;
    logic m_rdy, m_clk, m_sync, m_x, m_y, m_busy, m_done;
    assign m_rdy  = sel ? rdy1 : rdy0;
    assign m_clk  = sel ? c1   : c0;
    assign m_sync = sel ? s1   : s0;
    assign m_x    = sel ? dx1  : dx0;
    assign m_y    = sel ? dy1  : dy0;
    assign m_busy = sel ? b1   : b0;
    assign m_done = sel ? fd1  : fd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [19:0] fx;
        logic [19:0] fy;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        if (sel) begin x1 = x; y1 = y; v1 = 1'b1; end
        else     begin x0 = x; y0 = y; v0 = 1'b1; end
        check("send_ready", {31'd0, m_rdy}, 32'd1);
        @(posedge clk);
        #1;
        if (sel) v1 = 1'b0;
        else     v0 = 1'b0;
    endtask

    task automatic check_idle(input string nm);
        @(negedge clk);
        check({nm, "_lines"}, {26'd0, m_busy, m_clk, m_sync, m_x, m_y, m_done}, 32'd0);
        check({nm, "_ready"}, {31'd0, m_rdy}, 32'd1);
    endtask

    // Observes one full frame starting the cycle after the loading edge.
    task automatic check_frame(input string nm, input logic [19:0] ex, input logic [19:0] ey);
        logic [19:0] fx0, fxm, fy0, fym;
        int clk_err, sync_err, busy_err, done_cnt;
        logic done_last;
        fx0 = '0; fxm = '0; fy0 = '0; fym = '0;
        clk_err = 0; sync_err = 0; busy_err = 0; done_cnt = 0; done_last = 1'b0;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            if (m_clk !== ((k % BP) < (BP / 2))) clk_err++;
            if (m_sync !== ((k / BP) != 19)) sync_err++;
            if (m_busy !== 1'b1) busy_err++;
            if (m_done === 1'b1) done_cnt++;
            if (k == FL - 1) done_last = m_done;
            if ((k % BP) == 0) begin
                fx0 = {fx0[18:0], m_x};
                fy0 = {fy0[18:0], m_y};
            end
            if ((k % BP) == BP / 2) begin
                fxm = {fxm[18:0], m_x};
                fym = {fym[18:0], m_y};
            end
        end
        check({nm, "_x_start"}, {12'd0, fx0}, {12'd0, ex});
        check({nm, "_x_mid"},   {12'd0, fxm}, {12'd0, ex});
        check({nm, "_y_start"}, {12'd0, fy0}, {12'd0, ey});
        check({nm, "_y_mid"},   {12'd0, fym}, {12'd0, ey});
        check({nm, "_clk_errs"},  clk_err,  32'd0);
        check({nm, "_sync_errs"}, sync_err, 32'd0);
        check({nm, "_busy_errs"}, busy_err, 32'd0);
        check({nm, "_done_count"}, done_cnt, 32'd1);
        check({nm, "_done_last"}, {31'd0, done_last}, 32'd1);
    endtask

    initial begin
        // Frame = {001, data, 1 ^ ^data}, b0 first (MSB).
        vecs[0] = '{x: 16'h0000, y: 16'hFFFF, fx: 20'h20001, fy: 20'h3FFFF};
        vecs[1] = '{x: 16'h0001, y: 16'h8000, fx: 20'h20002, fy: 20'h30000};
        vecs[2] = '{x: 16'h1234, y: 16'hABCD, fx: 20'h22468, fy: 20'h3579B};
        vecs[3] = '{x: 16'h5A5A, y: 16'hA5A5, fx: 20'h2B4B5, fy: 20'h34B4B};

        sel = 1'b0;
        rst0_n = 1'b0; rst1_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        x0 = 16'h0; y0 = 16'h0; x1 = 16'h0; y1 = 16'h0;
        repeat (3) @(posedge clk);
        check_idle("reset0");
        sel = 1'b1;
        #1;
        check_idle("reset1");
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        sel = 1'b0;

        // Single frames with REPEAT=0, each followed by a return to IDLE.
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].x, vecs[i].y);
            check_frame($sformatf("vec%0d", i), vecs[i].fx, vecs[i].fy);
            check_idle($sformatf("vec%0d_idle", i));
        end

        // Two commands on consecutive cycles: second waits in the holding register.
        @(negedge clk);
        x0 = 16'h1234; y0 = 16'h1234; v0 = 1'b1;
        @(posedge clk);
        #1;
        x0 = 16'hABCD; y0 = 16'hABCD;
        fork
            check_frame("b2b_first", 20'h22468, 20'h22468);
            begin
                @(posedge clk);
                #1 v0 = 1'b0;
                @(negedge clk);
                check("b2b_held_ready", {31'd0, rdy0}, 32'd0);
                repeat (FL - 2) @(negedge clk);
                check("b2b_end_ready", {31'd0, rdy0}, 32'd0);
            end
        join
        fork
            check_frame("b2b_second", 20'h3579B, 20'h3579B);
            begin
                @(negedge clk);
                check("b2b_ready_back", {31'd0, rdy0}, 32'd1);
            end
        join
        check_idle("b2b_idle");

        // REPEAT=1: the last position resends with busy held high.
        sel = 1'b1;
        #1;
        send(16'h5A5A, 16'hA5A5);
        for (int i = 0; i < 3; i++) begin
            check_frame($sformatf("repeat%0d", i), 20'h2B4B5, 20'h34B4B);
        end

        // Command offered exactly on the frame-end cycle with an empty holding register.
        fork
            check_frame("bypass_prev", 20'h2B4B5, 20'h34B4B);
            begin
                repeat (FL) @(negedge clk);
                x1 = 16'h1234; y1 = 16'hABCD; v1 = 1'b1;
                check("bypass_ready", {31'd0, rdy1}, 32'd1);
                @(posedge clk);
                #1 v1 = 1'b0;
            end
        join
        check_frame("bypass_new", 20'h22468, 20'h3579B);
        check_frame("bypass_repeat", 20'h22468, 20'h3579B);

        // Fill the holding register, then reset at bit 10 of the frame.
        repeat (5 * BP) @(negedge clk);
        x1 = 16'hFFFF; y1 = 16'hFFFF; v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        @(negedge clk);
        check("hold_full_ready", {31'd0, rdy1}, 32'd0);
        repeat (5 * BP) @(negedge clk);
        rst1_n = 1'b0;
        check_idle("midreset");
        rst1_n = 1'b1;

        // Neither the held 0xFFFF nor the old position may survive the reset.
        send(16'h0000, 16'h0000);
        check_frame("post_reset", 20'h20001, 20'h20001);
        check_frame("post_reset_repeat", 20'h20001, 20'h20001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xy2_100_tx.md
# xy2_100_tx

XY2-100 command transmitter: accepts 16-bit X/Y galvo position commands on a valid/ready interface and serializes them as XY2-100 frames on CLOCK, SYNC, X and Y lines. It is the command-path counterpart to the scanner feedback receiver. It drives the galvo driver board directly from the laser control core. Each frame uses the same bit framing that the receiver decodes:
- control bits 0,0,1;
- 16 data bits, MSB first;
- one parity bit.

## Interface
Parameters:
- BIT_PERIOD, 20: clk cycles per protocol bit (100 MHz clk gives 5 MHz XY2 clock). Must be even and ≥4.
- REPEAT, 1: at frame end with no new command, 1 resends the last position and 0 returns to IDLE.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  command holding register can accept
- cmd_x  input  16  X position
- cmd_y  input  16  Y position
- xy2_clk  output  1  XY2-100 bit clock
- xy2_sync  output  1  frame sync
- xy2_x  output  1  X channel serial data
- xy2_y  output  1  Y channel serial data
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse on the last cycle of each frame

## Operation
- Frame: 20 bits, index b=0..19.
  - b0=0, b1=0, b2=1.
  - b3..b18 = data[15:0], MSB first.
  - b19 = parity = 1 ^ (XOR of data[15:0]).
- Each channel is encoded independently, with the same framing.
- States:
  - IDLE: all serial outputs 0; xy2_clk=0; busy=0.
  - SEND: busy=1.
- Counters:
  - period_cnt runs 0..BIT_PERIOD-1.
  - bit_cnt runs 0..19, advancing when period_cnt wraps.
- Line levels in SEND:
  - xy2_clk=1 for period_cnt < BIT_PERIOD/2, else 0. Data changes on the rising edge and is stable at the falling edge.
  - xy2_sync=1 for b0..b18 and 0 during b19.
- Command acceptance:
  - cmd_ready = holding register empty (reset value 1).
  - Acceptance means cmd_valid && cmd_ready.
  - IDLE + accept: IDLE→SEND, with the frame loaded directly from cmd_x/cmd_y.
  - SEND + accept: the command is stored in the holding register.
- Frame end (period_cnt=BIT_PERIOD-1, bit_cnt=19), first matching rule applies:
  1. Holding register full: load it, clear it, and stay in SEND back-to-back. cmd_ready=0 in this cycle.
  2. Holding register empty and cmd_valid: load cmd_x/cmd_y directly (bypass), acceptance counted, stay in SEND.
  3. REPEAT=1: reload the last sent X/Y and stay in SEND.
  4. Otherwise: go to IDLE.
- The last sent X/Y register resets to 0x0000. Frames are always complete; a new command never truncates a frame.
- Reset mid-frame: all outputs low and counters cleared on the next clk edge. The holding register and last position are cleared.

## Timing
- Reset values:
  - cmd_ready=1;
  - xy2_clk=0, xy2_sync=0, xy2_x=0, xy2_y=0;
  - busy=0, frame_done=0.
- All outputs are registered.
- Acceptance at cycle T in IDLE: b0 appears on the lines at T+1, with period_cnt=0, xy2_clk=1 and xy2_sync=1.
- The rising edge of the data line (b2) occurs at T+1+2·BIT_PERIOD.
- Frame length is 20·BIT_PERIOD cycles (400 at default).
- frame_done is high on the cycle T+20·BIT_PERIOD.
- Back-to-back frames: the next b0 follows with no gap cycle.
- Sustained throughput: one command per frame. A command offered during a frame waits at most one frame plus one cycle.

## Structure
- Package xy2_100_pkg holds:
  - FRAME_BITS=20;
  - CTRL_BITS=3'b001;
  - default BIT_PERIOD;
  - function xy2_parity(logic [15:0]) returning 1^(^d), shared with the receiver's check.
- Sub-module xy2_100_frame_ser, instantiated twice (X and Y):
  - 20-bit shift register;
  - inputs load, shift and data[15:0];
  - output of the current bit.
- Timing (period_cnt, bit_cnt, xy2_clk, xy2_sync) lives once in xy2_100_tx.

## Test plan
- Reset, then one command X=0x0000, Y=0xFFFF, REPEAT=0 → xy2_x bit sequence 0,0,1,0×16,1 and xy2_y 0,0,1,1×16,1. Each bit is 20 cycles; busy drops after 400 cycles; frame_done pulses once.
- Parity check: X=0x0001, Y=0x8000 → both b19=0. The loopback feedback receiver reports data 0x0001/0x8000 with valid=1 and even_check_wrong=0.
- Two commands on consecutive cycles (0x1234, then 0xABCD) → the first frames immediately and the second is held with cmd_ready=0. 0xABCD starts on the cycle after frame_done with no gap; cmd_ready returns to 1 then.
- REPEAT=1, single command 0x5A5A, no further valid → identical 0x5A5A frames repeat continuously and busy stays 1.
- cmd_valid asserted exactly on the frame-end cycle with holding register empty → bypass load. The next frame carries the new value and is accepted in that cycle.
- rst_n low at bit 10 of a frame → on the next edge all lines are 0, busy=0 and cmd_ready=1. A subsequent REPEAT frame sends 0x0000.
